riscv_mem_arbiter: RTL

Two-to-one memory request arbiter between the 5-stage RISCV core and a single-ported memory. It merges the core's instruction-fetch and data request streams onto one `memreq` port, tags each accepted request with its source, and routes in-order memory responses back to the originating core response port. It adds no cycles of latency. Its buffering is a small source-tag FIFO that bounds the number of outstanding requests.

---
 rtl/riscv_mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/riscv_mem_arbiter.sv
// Two-to-one round-robin arbiter merging instruction and data requests onto one
// memory port; a source-tag FIFO routes in-order responses back to their port.
module riscv_mem_arbiter #(
  parameter int REQ_SZ   = 67,
  parameter int RESP_SZ  = 35,
  parameter int MAX_OUTS = 4
) (
  input  logic               clk,
  input  logic               reset,

  input  logic [REQ_SZ-1:0]  imemreq_msg,
  input  logic               imemreq_val,
  output logic               imemreq_rdy,
  output logic [RESP_SZ-1:0] imemresp_msg,
  output logic               imemresp_val,

  input  logic [REQ_SZ-1:0]  dmemreq_msg,
  input  logic               dmemreq_val,
  output logic               dmemreq_rdy,
  output logic [RESP_SZ-1:0] dmemresp_msg,
  output logic               dmemresp_val,

  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,

  output logic               err
);

  localparam int PW = $clog2(MAX_OUTS);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTS);

  logic [MAX_OUTS-1:0] tags;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW:0]         count;
  logic                last_grant;
  logic                err_q;

  logic full;
  logic empty;
  logic grant_d;
  logic grant_i;
  logic fire;
  logic pop;
  logic head_tag;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Round-robin: on contention the port not served last wins.
  assign grant_d = dmemreq_val & (~imemreq_val | (last_grant == 1'b0));
  assign grant_i = imemreq_val & ~grant_d;

  assign memreq_val  = (imemreq_val | dmemreq_val) & ~full;
  assign memreq_msg  = grant_i ? imemreq_msg : dmemreq_msg;
  assign imemreq_rdy = grant_i & memreq_rdy & ~full;
  assign dmemreq_rdy = grant_d & memreq_rdy & ~full;

  assign fire     = memreq_val & memreq_rdy;
  assign pop      = memresp_val & ~empty;
  assign head_tag = tags[head];

  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = pop & (head_tag == 1'b0);
  assign dmemresp_val = pop & (head_tag == 1'b1);
  assign err          = err_q;

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (fire) begin
      tags[tail] <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (fire) begin
        tail       <= tail + 1'b1;
        last_grant <= grant_d;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (memresp_val & empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
